mmio_uart_tx: RTL and testbench
===============================

// Module: mmio_uart_tx
// PURPOSE
//   Memory-mapped UART transmitter on the CPU data bus (addr/wval/write/rval).
//   CPU stores to TXDATA push bytes into a small TX FIFO; a baud-rate FSM
//   serialises them 8N1 on tx. STATUS is readable in the same cycle, so
//   software can poll full/busy. rval is 0 on a miss, letting the top level
//   OR it with the data-RAM read value.
// PARAMETERS
//   BASE_ADDR     32'hFFFF_0000  base of the 8-byte register window (8-byte aligned)
//   CLKS_PER_BIT  16             clock cycles per serial bit (>=2)
//   FIFO_AW       2              log2 of FIFO depth (depth = 4)
// PORTS
//   clock   in   1   system clock, all state updates on posedge
//   nreset  in   1   asynchronous active-low reset
//   addr    in   32  CPU data address (ALU result)
//   wval    in   32  CPU store data
//   write   in   1   CPU store strobe, sampled at posedge
//   rval    out  32  read data (combinational); 0 when hit=0
//   hit     out  1   addr[31:3]==BASE_ADDR[31:3] (combinational)
//   tx      out  1   serial output, idle high
// BEHAVIOUR
//   Register map (addr[1:0] ignored):
//   - +0 TXDATA: write pushes wval[7:0]; reads return 0.
//   - +4 STATUS: read {24'b0, cnt[3:0], ovf, busy, empty, full} as bits[7:0]
//     (bit0 full, bit1 empty, bit2 busy, bit3 ovf, bits7:4 = FIFO count).
//     Writing STATUS with wval[3]=1 clears ovf; other bits are ignored.
//   Push: hit & write & addr[2]==0 at a posedge. If full and no pop at the
//     same edge, the byte is dropped and ovf is set (sticky). Push and pop at
//     the same edge while full: push accepted, count unchanged.
//   Pointers wrap modulo 2**FIFO_AW; count ranges 0..2**FIFO_AW.
//   FSM states: IDLE, START, DATA, STOP. baud counter 0..CLKS_PER_BIT-1;
//     bit index 0..7.
//   - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register,
//     clear the baud counter, and go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   - DATA: tx=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then
//     shift right. After bit 7, go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty,
//     pop and go directly to START (no gap); otherwise go to IDLE.
//   Timing: a byte pushed into an empty FIFO while in IDLE drives tx low from
//     the 2nd posedge after the write edge (pop edge +1 reg stage counted as 1).
//     The frame is exactly 10*CLKS_PER_BIT cycles.
//   tx is a registered output (glitch-free). busy=1 in any state except IDLE.
//   Reset (async, any time, including mid-frame): state=IDLE, tx=1 immediately,
//     FIFO empty (ptrs and cnt 0), ovf=0, baud counter and bit index 0.
//     The frame in progress is abandoned.
//   rval and hit depend only on addr and current state (no write-through of wval).
// TESTING (CLKS_PER_BIT=4, FIFO_AW=2, BASE=FFFF0000)
//   1 reset: hold nreset=0 -> tx=1, read FFFF0004 gives rval=0x00000002;
//     read 00001000 gives hit=0, rval=0.
//   2 single byte: store 0x55 to FFFF0000 -> tx=0 for 4 cycles, then
//     1,0,1,0,1,0,1,0 at 4 cycles each, then stop=1 for 4 cycles; busy=1
//     throughout, then STATUS=0x02.
//   3 back-to-back: push A5,3C on consecutive cycles -> the two frames are
//     contiguous (80 cycles total, no idle gap); cnt reads 1 during frame 1.
//   4 overflow: push 6 bytes back-to-back -> the first 5 are transmitted
//     (1 in flight + 4 queued), the 6th is dropped, STATUS bit3=1; store 0x08
//     to FFFF0004 -> bit3=0.
//   5 reset mid-frame: assert nreset during DATA bit 3 -> tx=1 in the same
//     cycle, STATUS=0x02 after release, no residual frame.
//   6 push+pop same edge when full: full FIFO, push at the STOP->START edge ->
//     byte accepted, cnt stays 4, ovf stays 0.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Stores to TXDATA queue bytes. A baud-rate FSM shifts them out LSB first on tx.
// STATUS reads back combinationally, so software can poll full/busy in the same cycle.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_AW      = 2
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [31:0] addr,
  input  logic [31:0] wval,
  input  logic        write,
  output logic [31:0] rval,
  output logic        hit,
  output logic        tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state, state_next;
  logic [BW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic               ovf;

  logic baud_end, full, empty, busy, pop, tx_next;
  logic push_req, push_ok, drop, stat_clr;
  logic [3:0]  cnt4;
  logic [31:0] status;
  logic        unused_ok;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  assign full     = (cnt == (FIFO_AW + 1)'(DEPTH));
  assign empty    = (cnt == '0);

  // Bus decode: the window is 8 bytes, bit 2 picks TXDATA/STATUS, bits 1:0 ignored.
  assign hit      = (addr[31:3] == BASE_ADDR[31:3]);
  assign push_req = hit & write & ~addr[2];
  assign stat_clr = hit & write & addr[2] & wval[3];
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign cnt4      = 4'(cnt);
  assign status    = {24'b0, cnt4, ovf, busy, empty, full};
  assign rval      = (hit & addr[2]) ? status : 32'b0;
  assign unused_ok = ^{addr[1:0], wval[31:8], wval[7:4], wval[2:0]};

  // FSM state register.
  always_ff @(posedge clock or negedge nreset) begin
    // NOTE: clocked state always uses <= so every register samples pre-edge values.
    if (!nreset) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: the default assignment up front keeps this purely combinational (no latch).
    state_next = state;
    case (state)
      S_IDLE:  if (!empty) state_next = S_START;
      S_START: if (baud_end) state_next = S_DATA;
      S_DATA:  if (baud_end && bit_idx == 3'd7) state_next = S_STOP;
      S_STOP:  if (baud_end) state_next = empty ? S_IDLE : S_START;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: FIFO pop strobe, serial level for the tx register, busy flag.
  always_comb begin
    pop     = 1'b0;
    tx_next = 1'b1;
    busy    = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        pop  = !empty;
      end
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift[0];
      S_STOP:  pop     = baud_end & !empty;
      default: busy    = 1'b0;
    endcase
  end

  // Registered serial output so tx never glitches; forced idle-high on reset.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) tx <= 1'b1;
    else         tx <= tx_next;
  end

  // Baud counter, bit index and shift register; a pop restarts a frame.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (pop) begin
      baud    <= '0;
      bit_idx <= '0;
      shift   <= mem[rd_ptr];
    end else begin
      case (state)
        S_START, S_STOP: baud <= baud_end ? '0 : baud + 1'b1;
        S_DATA: begin
          if (baud_end) begin
            baud    <= '0;
            bit_idx <= bit_idx + 3'd1;
            shift   <= shift >> 1;
          end else begin
            baud    <= baud + 1'b1;
          end
        end
        default: baud <= '0;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clock) begin
    // NOTE: storage has no reset; empty pointers make stale contents unreachable.
    if (push_ok) mem[wr_ptr] <= wval[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop)          ovf <= 1'b1;
      else if (stat_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx. A cycle-level reference model keeps a
// byte queue for the FIFO, a queue of expected serial levels and a frame-time
// countdown. Directed scenarios are followed by a randomized bus phase.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] STAT  = 32'hFFFF_0004;

  logic        clock  = 1'b0;
  logic        nreset = 1'b0;
  logic        write  = 1'b0;
  logic [31:0] addr   = 32'h0;
  logic [31:0] wval   = 32'h0;
  logic [31:0] rval;
  logic        hit;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (2)
  ) dut (
    .clock (clock),
    .nreset(nreset),
    .addr  (addr),
    .wval  (wval),
    .write (write),
    .rval  (rval),
    .hit   (hit),
    .tx    (tx)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] fifo_q[$];
  bit         stream_q[$];
  int         rem    = 0;
  bit         m_ovf  = 1'b0;
  bit         exp_tx = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_hit(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = 32'h0;
    s[7:4] = 4'(fifo_q.size());
    s[3]   = m_ovf;
    s[2]   = (rem > 0);
    s[1]   = (fifo_q.size() == 0);
    s[0]   = (fifo_q.size() == DEPTH);
    return s;
  endfunction

  function automatic logic [31:0] exp_rval(input logic [31:0] a);
    return (is_hit(a) && a[2]) ? exp_status() : 32'h0;
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    stream_q.delete();
    rem    = 0;
    m_ovf  = 1'b0;
    exp_tx = 1'b1;
  endtask

  // Advance the model by one clock edge given the bus inputs seen at that edge.
  task automatic model_edge(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int         cnt0;
    bit         pop;
    bit         push;
    logic [7:0] b;
    cnt0   = fifo_q.size();
    pop    = (cnt0 > 0) && (rem <= 1);
    push   = wr && is_hit(a) && !a[2];
    exp_tx = (stream_q.size() > 0) ? stream_q.pop_front() : 1'b1;
    if (pop) begin
      b = fifo_q.pop_front();
      repeat (CPB) stream_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) stream_q.push_back(b[i]);
      repeat (CPB) stream_q.push_back(1'b1);
      rem = 10 * CPB;
    end else if (rem > 0) begin
      rem--;
    end
    if (push) begin
      if (cnt0 == DEPTH && !pop) m_ovf = 1'b1;
      else                       fifo_q.push_back(d[7:0]);
    end
    if (wr && is_hit(a) && a[2] && d[3]) m_ovf = 1'b0;
  endtask

  // Apply bus inputs, clock one edge, then compare all outputs 1 ns later.
  task automatic cycle(input bit wr, input logic [31:0] a, input logic [31:0] d);
    write = wr;
    addr  = a;
    wval  = d;
    @(posedge clock);
    model_edge(wr, a, d);
    #1;
    check("tx", 32'(tx), 32'(exp_tx));
    check("hit", 32'(hit), 32'(is_hit(a)));
    check("rval", rval, exp_rval(a));
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    repeat (n) cycle(1'b0, a, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         guard;
    int         r;
    logic [31:0] a;

    // 1: reset state, read while held in reset.
    nreset = 1'b0;
    addr   = STAT;
    #12;
    check("reset_tx", 32'(tx), 32'h1);
    check("reset_status", rval, 32'h2);
    check("reset_hit", 32'(hit), 32'h1);
    addr = 32'h0000_1000;
    #1;
    check("miss_hit", 32'(hit), 32'h0);
    check("miss_rval", rval, 32'h0);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();

    // 2: single byte 0x55.
    cycle(1'b1, BASE, 32'h55);
    idle(45, STAT);
    check("t2_status", rval, 32'h2);

    // 3: two bytes on consecutive cycles form contiguous frames.
    cycle(1'b1, BASE, 32'hA5);
    cycle(1'b1, BASE, 32'h3C);
    idle(85, STAT);
    check("t3_status", rval, 32'h2);

    // 4: six back-to-back pushes, the sixth overflows; then clear ovf.
    for (int i = 0; i < 6; i++) cycle(1'b1, BASE, 32'($urandom_range(0, 255)));
    cycle(1'b0, STAT, 32'h0);
    check("t4_ovf_set", 32'(rval[3]), 32'h1);
    idle(205, STAT);
    cycle(1'b1, STAT, 32'h8);
    check("t4_ovf_clr", rval, 32'h2);

    // 6: fill the FIFO, then push exactly at the STOP->START edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, BASE, 32'($urandom_range(0, 255)));
    guard = 0;
    while (rem != 1 && guard < 100) begin
      cycle(1'b0, STAT, 32'h0);
      guard++;
    end
    check("t6_align_in_time", 32'(guard < 100), 32'h1);
    cycle(1'b1, BASE, 32'h99);
    cycle(1'b0, STAT, 32'h0);
    check("t6_cnt", 32'(rval[7:4]), 32'h4);
    check("t6_ovf", 32'(rval[3]), 32'h0);
    idle(250, STAT);
    check("t6_status", rval, 32'h2);

    // 5: reset in the middle of data bit 3 (0xF0 has bit 3 low).
    cycle(1'b1, BASE, 32'hF0);
    idle(19, STAT);
    check("t5_pre_tx", 32'(tx), 32'h0);
    nreset = 1'b0;
    #1;
    check("t5_tx_async", 32'(tx), 32'h1);
    model_reset();
    check("t5_status_rst", rval, 32'h2);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    idle(50, STAT);
    check("t5_status", rval, 32'h2);

    // Random bus traffic: pushes, STATUS writes, misses and reads.
    repeat (500) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        a = BASE | 32'($urandom_range(0, 3));
        cycle(1'b1, a, $urandom);
      end else if (r < 30) begin
        a = STAT | 32'($urandom_range(0, 3));
        cycle(1'b1, a, $urandom);
      end else if (r < 40) begin
        a = $urandom & 32'h7FFF_FFFF;
        cycle(1'($urandom_range(0, 1)), a, $urandom);
      end else begin
        cycle(1'b0, STAT, 32'h0);
      end
    end
    idle(250, STAT);
    check("rand_drain_cnt", 32'(rval[7:4]), 32'h0);
    check("rand_drain_busy", 32'(rval[2]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
